// File: rtl/shreg_pkg.sv
// ---------------------------------------------------------------------------
// shreg_pkg
// Shared definitions for the d_shift_register slice.
//   mode_e  : operation selector carried on the 3-bit mode port
//   state_e : burst sequencer states
//   is_burst_mode : true for the modes that move bits (SHL..ASR), which are
//                   the only modes a burst actually steps with
// ---------------------------------------------------------------------------
package shreg_pkg;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'd0,
      MODE_LOAD  = 3'd1,
      MODE_SHL   = 3'd2,
      MODE_SHR   = 3'd3,
      MODE_ROL   = 3'd4,
      MODE_ROR   = 3'd5,
      MODE_ASR   = 3'd6,
      MODE_CLEAR = 3'd7
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic is_burst_mode(input mode_e m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
             (m == MODE_ROR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational one-bit move of the register value. Shared by the single-op
// path and the burst sequencer so both produce identical results.
// Ports:
//   q       in  WIDTH  current register value
//   sin     in  1      serial fill bit (SHL fills bit0, SHR fills MSB)
//   mode    in  mode_e operation to apply
//   next_q  out WIDTH  value after one step (q itself for non-moving modes)
//   out_bit out 1      bit shifted or rotated out
//   moves   out 1      high when mode moves bits, i.e. sout should update
// ---------------------------------------------------------------------------
module shift_step
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic             sin,
   input  mode_e            mode,
   output logic [WIDTH-1:0] next_q,
   output logic             out_bit,
   output logic             moves
);

   // LOAD, CLEAR and HOLD are not moves; the top handles LOAD/CLEAR itself.
   always_comb begin
      next_q  = q;
      out_bit = 1'b0;
      moves   = 1'b1;
      case (mode)
         MODE_SHL: begin
            next_q  = {q[WIDTH-2:0], sin};
            out_bit = q[WIDTH-1];
         end
         MODE_SHR: begin
            next_q  = {sin, q[WIDTH-1:1]};
            out_bit = q[0];
         end
         MODE_ROL: begin
            next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            out_bit = q[WIDTH-1];
         end
         MODE_ROR: begin
            next_q  = {q[0], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         MODE_ASR: begin
            next_q  = {q[WIDTH-1], q[WIDTH-1:1]};
            out_bit = q[0];
         end
         default: begin
            moves = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/d_shift_register.sv
// ---------------------------------------------------------------------------
// d_shift_register
// WIDTH-bit storage/shift element with single-cycle ops and multi-cycle
// burst shifts sequenced by a small IDLE/RUN/DONE FSM.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      synchronous active-high reset
//   en      in  1      perform one op per mode this cycle (IDLE only)
//   start   in  1      begin a burst of `amount` steps (wins over en)
//   mode    in  3      HOLD/LOAD/SHL/SHR/ROL/ROR/ASR/CLEAR
//   amount  in  AMT_W  burst step count, sampled with start
//   data    in  WIDTH  parallel load value
//   sin     in  1      serial fill bit, sampled every step
//   Q       out WIDTH  register contents
//   _Q      out WIDTH  inverse of Q
//   sout    out 1      last bit shifted/rotated out
//   busy    out 1      burst steps in progress
//   done    out 1      one-cycle pulse when a burst request completes
// ---------------------------------------------------------------------------
module d_shift_register
   import shreg_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data,
   input  logic             sin,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] _Q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e           state, state_n;
   mode_e            run_mode, run_mode_n;
   logic [AMT_W-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] q_n;
   logic             sout_n;

   mode_e            in_mode;
   mode_e            step_mode;
   logic [WIDTH-1:0] step_q;
   logic             step_out;
   logic             step_moves;

   assign in_mode = mode_e'(mode);

   // During a burst the latched mode drives the step, so mode may change freely.
   assign step_mode = (state == ST_RUN) ? run_mode : in_mode;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .q       (Q),
      .sin     (sin),
      .mode    (step_mode),
      .next_q  (step_q),
      .out_bit (step_out),
      .moves   (step_moves)
   );

   // State, data and counter registers; reset clears everything and aborts
   // any burst without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         run_mode <= MODE_HOLD;
         cnt      <= '0;
         Q        <= '0;
         sout     <= 1'b0;
      end else begin
         state    <= state_n;
         run_mode <= run_mode_n;
         cnt      <= cnt_n;
         Q        <= q_n;
         sout     <= sout_n;
      end
   end

   // Next-state logic. A start that cannot move bits (zero amount or a
   // non-moving mode) skips RUN and goes straight to the done pulse.
   always_comb begin
      state_n    = state;
      run_mode_n = run_mode;
      cnt_n      = cnt;
      q_n        = Q;
      sout_n     = sout;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if ((amount != '0) && is_burst_mode(in_mode)) begin
                  state_n    = ST_RUN;
                  run_mode_n = in_mode;
                  cnt_n      = amount;
               end else begin
                  state_n = ST_DONE;
               end
            end else if (en) begin
               case (in_mode)
                  MODE_LOAD:  q_n = data;
                  MODE_CLEAR: q_n = '0;
                  default: begin
                     q_n = step_q;
                     if (step_moves) sout_n = step_out;
                  end
               endcase
            end
         end
         ST_RUN: begin
            q_n    = step_q;
            sout_n = step_out;
            cnt_n  = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1)) state_n = ST_DONE;
         end
         ST_DONE: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   assign _Q   = ~Q;
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_d_shift_register.sv
// ---------------------------------------------------------------------------
// tb_d_shift_register
// Self-checking bench for d_shift_register (WIDTH=8). A behavioural model
// tracks the expected register and sout values using plain integer
// arithmetic; each scenario task drives stimulus and compares inline.
// ---------------------------------------------------------------------------
module tb_d_shift_register;

   localparam int W = 8;
   localparam int AW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    mode = 3'd0;
   logic [AW-1:0] amount = '0;
   logic [W-1:0]  data = '0;
   logic          sin = 1'b0;
   logic [W-1:0]  Q;
   logic [W-1:0]  _Q;
   logic          sout;
   logic          busy;
   logic          done;

   int asserts = 0;
   int failures = 0;

   // Reference model state
   int m_q = 0;
   int m_sout = 0;

   d_shift_register #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .start  (start),
      .mode   (mode),
      .amount (amount),
      .data   (data),
      .sin    (sin),
      .Q      (Q),
      ._Q     (_Q),
      .sout   (sout),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One bit move using integer arithmetic on the model value.
   function automatic void model_move(input int m, input int s);
      int o;
      case (m)
         2: begin o = (m_q >> 7) & 1; m_q = ((m_q << 1) | s) & 255; m_sout = o; end
         3: begin o = m_q & 1; m_q = (m_q >> 1) | (s << 7); m_sout = o; end
         4: begin o = (m_q >> 7) & 1; m_q = ((m_q << 1) | o) & 255; m_sout = o; end
         5: begin o = m_q & 1; m_q = (m_q >> 1) | (o << 7); m_sout = o; end
         6: begin o = m_q & 1; m_q = (m_q >> 1) | (m_q & 128); m_sout = o; end
         default: ;
      endcase
   endfunction

   // Single-cycle op with en=1.
   function automatic void model_single(input int m, input int d, input int s);
      if (m == 1) m_q = d & 255;
      else if (m == 7) m_q = 0;
      else model_move(m, s);
   endfunction

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; start = 1'b0;
      tick(); tick();
      m_q = 0; m_sout = 0;
      asserts++;
      if (Q !== 8'h00) begin failures++; $display("[TB] FAIL reset_q: got %h expected 00", Q); end
      asserts++;
      if (_Q !== 8'hFF) begin failures++; $display("[TB] FAIL reset_nq: got %h expected ff", _Q); end
      asserts++;
      if (busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_flags: got busy=%b done=%b sout=%b expected 0 0 0", busy, done, sout);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_directed();
      en = 1'b1; mode = 3'd1; data = 8'hA5; sin = 1'b0;
      tick();
      model_single(1, 'hA5, 0);
      asserts++;
      if (Q !== 8'hA5) begin failures++; $display("[TB] FAIL load: got %h expected a5", Q); end
      mode = 3'd2; sin = 1'b1;
      tick();
      model_single(2, 0, 1);
      asserts++;
      if (Q !== 8'h4B || sout !== 1'b1) begin
         failures++; $display("[TB] FAIL shl: got %h/%b expected 4b/1", Q, sout);
      end
      mode = 3'd6; sin = 1'b0;
      tick();
      model_single(6, 0, 0);
      asserts++;
      if (Q !== 8'h25 || sout !== 1'b1) begin
         failures++; $display("[TB] FAIL asr: got %h/%b expected 25/1", Q, sout);
      end
      en = 1'b0; mode = 3'd7;
      tick();
      asserts++;
      if (Q !== 8'h25) begin failures++; $display("[TB] FAIL en_low_hold: got %h expected 25", Q); end
   endtask

   task automatic test_single_random();
      int m, d, s, e;
      for (int i = 0; i < 60; i++) begin
         m = int'($urandom_range(0, 7));
         d = int'($urandom_range(0, 255));
         s = int'($urandom_range(0, 1));
         e = ($urandom_range(0, 3) != 0) ? 1 : 0;
         mode = m[2:0]; data = d[7:0]; sin = s[0]; en = e[0];
         tick();
         if (e == 1) model_single(m, d, s);
         asserts++;
         if (Q !== m_q[7:0] || _Q !== ~m_q[7:0] || sout !== m_sout[0] || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_rand mode=%0d: got Q=%h nQ=%h sout=%b busy=%b expected Q=%h sout=%0d busy=0",
                     m, Q, _Q, sout, busy, m_q[7:0], m_sout);
         end
      end
      en = 1'b0;
   endtask

   // Issue a burst request and follow it to completion, checking busy
   // length, done pulse and final contents against the model.
   task automatic do_burst(input int m, input int amt, input bit rand_sin,
                           input int fixed_sin, input bit noise, input bit with_en);
      int exp_busy, cycles, s, r;
      exp_busy = (amt != 0 && m >= 2 && m <= 6) ? amt : 0;
      start = 1'b1; mode = m[2:0]; amount = amt[AW-1:0]; en = with_en;
      data = 8'h3C;
      tick();
      start = 1'b0;
      cycles = 0;
      while (busy === 1'b1 && cycles < 40) begin
         cycles++;
         s = rand_sin ? int'($urandom_range(0, 1)) : fixed_sin;
         sin = s[0];
         if (noise) begin
            r = int'($urandom);
            en = r[0]; start = r[1]; mode = r[4:2]; data = r[12:5]; amount = r[16:13];
         end
         tick();
         model_move(m, s);
      end
      start = 1'b0; en = 1'b0;
      asserts++;
      if (cycles !== exp_busy) begin
         failures++; $display("[TB] FAIL burst_busy_len mode=%0d amt=%0d: got %0d expected %0d", m, amt, cycles, exp_busy);
      end
      asserts++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL burst_done mode=%0d amt=%0d: got done=%b busy=%b expected 1 0", m, amt, done, busy);
      end
      asserts++;
      if (Q !== m_q[7:0] || sout !== m_sout[0]) begin
         failures++;
         $display("[TB] FAIL burst_result mode=%0d amt=%0d: got %h/%b expected %h/%0d", m, amt, Q, sout, m_q[7:0], m_sout);
      end
      tick();
      asserts++;
      if (done !== 1'b0 || busy !== 1'b0 || Q !== m_q[7:0]) begin
         failures++; $display("[TB] FAIL burst_after mode=%0d: got done=%b busy=%b Q=%h expected 0 0 %h", m, done, busy, Q, m_q[7:0]);
      end
   endtask

   task automatic load_value(input int v);
      en = 1'b1; mode = 3'd1; data = v[7:0];
      tick();
      model_single(1, v, 0);
      en = 1'b0;
   endtask

   task automatic test_burst_rol();
      load_value('h81);
      do_burst(4, 3, 1'b1, 0, 1'b0, 1'b0);
      asserts++;
      if (Q !== 8'h0C || sout !== 1'b0) begin
         failures++; $display("[TB] FAIL rol3: got %h/%b expected 0c/0", Q, sout);
      end
   endtask

   task automatic test_burst_long_shr();
      load_value('hF0);
      do_burst(3, 10, 1'b0, 0, 1'b1, 1'b0);
      asserts++;
      if (Q !== 8'h00) begin failures++; $display("[TB] FAIL shr10: got %h expected 00", Q); end
   endtask

   task automatic test_burst_degenerate();
      load_value('h5A);
      do_burst(2, 0, 1'b1, 0, 1'b0, 1'b1);
      asserts++;
      if (Q !== 8'h5A) begin failures++; $display("[TB] FAIL amt0: got %h expected 5a", Q); end
      do_burst(1, 4, 1'b1, 0, 1'b0, 1'b1);
      do_burst(7, 4, 1'b1, 0, 1'b0, 1'b1);
      asserts++;
      if (Q !== 8'h5A) begin failures++; $display("[TB] FAIL nonmove_burst: got %h expected 5a", Q); end
      do_burst(5, 2, 1'b1, 0, 1'b0, 1'b1);
      asserts++;
      if (Q !== 8'h96) begin failures++; $display("[TB] FAIL start_over_en: got %h expected 96", Q); end
   endtask

   task automatic test_burst_random();
      for (int i = 0; i < 12; i++) begin
         load_value(int'($urandom_range(0, 255)));
         do_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 1'b1, 0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_reset_mid_burst();
      load_value('hC3);
      start = 1'b1; mode = 3'd2; amount = 4'd5; sin = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_q = 0; m_sout = 0;
      asserts++;
      if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
         failures++; $display("[TB] FAIL rst_mid: got Q=%h busy=%b done=%b sout=%b expected 00 0 0 0", Q, busy, done, sout);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         asserts++;
         if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'h00) begin
            failures++; $display("[TB] FAIL rst_mid_after cyc=%0d: got done=%b busy=%b Q=%h expected 0 0 00", i, done, busy, Q);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_directed();
      test_single_random();
      test_burst_rol();
      test_burst_long_shr();
      test_burst_degenerate();
      test_burst_random();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
